// File: rtl/master_req_queue_pkg.sv
// Shared definitions for the crossbar master-side request queue.
// The command encodings are also used by the crossbar.
package master_req_queue_pkg;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } mrq_state_e;

endpackage

// File: rtl/master_req_queue_req_fifo.sv
// Synchronous FIFO holding {cmd, addr, wdata} entries for the request queue.
// The head entry stays visible on rdata until it is popped.
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk_sys,
    input  logic                     rst_b,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/master_req_queue.sv
// Master-side request queue: buffers core transactions and issues them one at
// a time to a crossbar master port, returning read data as one-cycle responses.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction in flight; latch FIFO head when one is queued
// REQ    | m_req high, outputs stable; m_ack pops the head
// RDWAIT | read accepted, counting RD_LAT cycles until m_rdata is valid
// RESP   | resp_valid pulse for the captured read data
module master_req_queue
    import master_req_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                     clk_sys,
    input  logic                     rst_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_cmd,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_wdata,
    output logic                     resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     m_req,
    output logic                     m_cmd,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_wdata,
    input  logic                     m_ack,
    input  logic [DATA_W-1:0]        m_rdata
);

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam logic [1:0] LAT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    mrq_state_e         state;
    mrq_state_e         state_nxt;
    logic [ENTRY_W-1:0] head;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [1:0]         lat_cnt;
    logic               load_head;
    logic               load_cnt;
    logic               cap_rdata;

    assign in_ready  = rst_b & ~fifo_full;
    assign fifo_push = in_valid & in_ready;

    req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_req_fifo (
        .clk_sys (clk_sys),
        .rst_b   (rst_b),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   ({in_cmd, in_addr, in_wdata}),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        load_cnt  = 1'b0;
        cap_rdata = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load_head = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (m_ack) begin
                    fifo_pop = 1'b1;
                    if (m_cmd == CMD_WR) begin
                        state_nxt = IDLE;
                    end else if (RD_LAT == 0) begin
                        cap_rdata = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        load_cnt  = 1'b1;
                        state_nxt = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (lat_cnt == 2'd0) begin
                    cap_rdata = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Down-counter loaded with RD_LAT-1 so terminal count lands on the data cycle.
    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            m_cmd     <= CMD_RD;
            m_addr    <= '0;
            m_wdata   <= '0;
            resp_data <= '0;
            lat_cnt   <= '0;
        end else begin
            if (load_head) {m_cmd, m_addr, m_wdata} <= head;
            if (cap_rdata) resp_data <= m_rdata;
            if (load_cnt)
                lat_cnt <= LAT_LOAD;
            else if (state == RDWAIT && lat_cnt != 2'd0)
                lat_cnt <= lat_cnt - 1'b1;
        end
    end

    assign m_req      = (state == REQ);
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_master_req_queue.sv
// Directed bench for master_req_queue; three instances cover RD_LAT = 1, 0, 3.
// Index 0: RD_LAT=1, index 1: RD_LAT=0, index 2: RD_LAT=3.
module tb_master_req_queue;

    logic        clk_sys = 1'b0;
    logic        rst_b;
    logic        in_cmd;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] m_rdata;

    logic        in_valid   [3];
    logic        m_ack      [3];
    logic        in_ready   [3];
    logic        resp_valid [3];
    logic        m_req      [3];
    logic        m_cmd      [3];
    logic [31:0] resp_data  [3];
    logic [31:0] m_addr     [3];
    logic [31:0] m_wdata    [3];
    logic [2:0]  level      [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    master_req_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_lat1 (
        .clk_sys(clk_sys), .rst_b(rst_b), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_cmd(in_cmd), .in_addr(in_addr), .in_wdata(in_wdata),
        .resp_valid(resp_valid[0]), .resp_data(resp_data[0]), .level(level[0]),
        .m_req(m_req[0]), .m_cmd(m_cmd[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_ack(m_ack[0]), .m_rdata(m_rdata));

    master_req_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RD_LAT(0)) u_lat0 (
        .clk_sys(clk_sys), .rst_b(rst_b), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_cmd(in_cmd), .in_addr(in_addr), .in_wdata(in_wdata),
        .resp_valid(resp_valid[1]), .resp_data(resp_data[1]), .level(level[1]),
        .m_req(m_req[1]), .m_cmd(m_cmd[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_ack(m_ack[1]), .m_rdata(m_rdata));

    master_req_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_lat3 (
        .clk_sys(clk_sys), .rst_b(rst_b), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_cmd(in_cmd), .in_addr(in_addr), .in_wdata(in_wdata),
        .resp_valid(resp_valid[2]), .resp_data(resp_data[2]), .level(level[2]),
        .m_req(m_req[2]), .m_cmd(m_cmd[2]), .m_addr(m_addr[2]), .m_wdata(m_wdata[2]),
        .m_ack(m_ack[2]), .m_rdata(m_rdata));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic reset_seq();
        rst_b    = 1'b0;
        in_cmd   = 1'b0;
        in_addr  = '0;
        in_wdata = '0;
        m_rdata  = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            m_ack[i]    = 1'b0;
        end
        tick();
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    task automatic push(input int k, input logic cmd, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic accepted);
        in_valid[k] = 1'b1;
        in_cmd      = cmd;
        in_addr     = addr;
        in_wdata    = wdata;
        accepted    = in_ready[k];
        tick();
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_req(input int k, input string tag);
        int n;
        n = 0;
        while (!m_req[k] && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_req_seen"}, 32'(m_req[k]), 32'd1);
    endtask

    task automatic ack_pulse(input int k);
        m_ack[k] = 1'b1;
        tick();
        m_ack[k] = 1'b0;
    endtask

    task automatic run_mixed(input int k, input int lat);
        logic        acc;
        logic        is_wr;
        logic [31:0] rd;
        reset_seq();
        push(k, 1'b0, 32'h10, 32'h0,  acc);
        push(k, 1'b1, 32'h20, 32'h55, acc);
        push(k, 1'b0, 32'h30, 32'h0,  acc);
        for (int j = 0; j < 3; j++) begin
            is_wr = (j == 1);
            rd    = 32'hC0DE_0000 + 32'(lat * 256 + j);
            wait_req(k, "mix");
            check_eq("mix_cmd",  32'(m_cmd[k]), 32'(is_wr));
            check_eq("mix_addr", m_addr[k], 32'h10 + 32'(j * 16));
            m_ack[k] = 1'b1;
            m_rdata  = (lat == 0) ? rd : 32'hBAD0_BAD0;
            tick();
            m_ack[k] = 1'b0;
            check_eq("mix_gap", 32'(m_req[k]), 32'd0);
            if (!is_wr) begin
                for (int c = 1; c <= lat; c++) begin
                    m_rdata = (c == lat) ? rd : 32'hBAD0_BAD0;
                    check_eq("mix_early_resp", 32'(resp_valid[k]), 32'd0);
                    tick();
                end
                m_rdata = 32'hBAD0_BAD0;
                check_eq("mix_resp_valid", 32'(resp_valid[k]), 32'd1);
                check_eq("mix_resp_data",  resp_data[k], rd);
            end else begin
                check_eq("mix_wr_no_resp", 32'(resp_valid[k]), 32'd0);
            end
        end
        check_eq("mix_level_end", 32'(level[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic seen;

        // Reset state
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            m_ack[i]    = 1'b0;
        end
        in_cmd = 1'b0; in_addr = '0; in_wdata = '0; m_rdata = '0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_in_ready",   32'(in_ready[k]),   32'd0);
            check_eq("rst_m_req",      32'(m_req[k]),      32'd0);
            check_eq("rst_level",      32'(level[k]),      32'd0);
            check_eq("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
            check_eq("rst_m_addr",     m_addr[k],          32'd0);
            check_eq("rst_resp_data",  resp_data[k],       32'd0);
        end
        rst_b = 1'b1;
        tick();
        check_eq("rel_in_ready", 32'(in_ready[0]), 32'd1);

        // Single write with delayed ack
        push(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, acc);
        check_eq("wr_accepted", 32'(acc), 32'd1);
        check_eq("wr_idle_req", 32'(m_req[0]), 32'd0);
        check_eq("wr_level1",   32'(level[0]), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("wr_req",   32'(m_req[0]), 32'd1);
            check_eq("wr_cmd",   32'(m_cmd[0]), 32'd1);
            check_eq("wr_addr",  m_addr[0],     32'h8000_0010);
            check_eq("wr_wdata", m_wdata[0],    32'hDEAD_BEEF);
            if (i < 3) tick();
        end
        ack_pulse(0);
        check_eq("wr_req_drop",  32'(m_req[0]),      32'd0);
        check_eq("wr_level0",    32'(level[0]),      32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid[0] || m_req[0]) seen = 1'b1;
            tick();
        end
        check_eq("wr_quiet", 32'(seen), 32'd0);

        // Single read, RD_LAT=1
        push(0, 1'b0, 32'h0000_0004, 32'h0, acc);
        tick();
        check_eq("rd_req",  32'(m_req[0]), 32'd1);
        check_eq("rd_cmd",  32'(m_cmd[0]), 32'd0);
        check_eq("rd_addr", m_addr[0],     32'h0000_0004);
        m_ack[0] = 1'b1;
        m_rdata  = 32'hFFFF_0000;
        tick();
        m_ack[0] = 1'b0;
        m_rdata  = 32'h1234_5678;
        check_eq("rd_req_drop", 32'(m_req[0]),      32'd0);
        check_eq("rd_no_resp1", 32'(resp_valid[0]), 32'd0);
        tick();
        m_rdata = 32'h0;
        check_eq("rd_resp_valid", 32'(resp_valid[0]), 32'd1);
        check_eq("rd_resp_data",  resp_data[0],        32'h1234_5678);
        tick();
        check_eq("rd_resp_pulse", 32'(resp_valid[0]), 32'd0);
        check_eq("rd_resp_hold",  resp_data[0],        32'h1234_5678);

        // Fill past DEPTH with acks stuck low, then drain in order
        reset_seq();
        for (int i = 0; i < 5; i++) begin
            push(0, 1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), acc);
            check_eq("fill_accept", 32'(acc), 32'(i < 4));
        end
        check_eq("fill_level",    32'(level[0]),    32'd4);
        check_eq("fill_in_ready", 32'(in_ready[0]), 32'd0);
        for (int j = 0; j < 4; j++) begin
            wait_req(0, "drain");
            check_eq("drain_addr",  m_addr[0],  32'h100 + 32'(j * 4));
            check_eq("drain_wdata", m_wdata[0], 32'hA0 + 32'(j));
            ack_pulse(0);
            check_eq("drain_gap", 32'(m_req[0]), 32'd0);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_req[0]) seen = 1'b1;
        end
        check_eq("drain_no_extra", 32'(seen),      32'd0);
        check_eq("drain_level0",   32'(level[0]),  32'd0);

        // Mixed R, W, R at RD_LAT=0 and RD_LAT=3
        run_mixed(1, 0);
        run_mixed(2, 3);

        // Spurious acks in IDLE and RESP
        reset_seq();
        m_ack[0] = 1'b1;
        tick();
        tick();
        m_ack[0] = 1'b0;
        check_eq("sp_idle_level", 32'(level[0]), 32'd0);
        check_eq("sp_idle_req",   32'(m_req[0]), 32'd0);
        push(0, 1'b0, 32'h40, 32'h0,  acc);
        push(0, 1'b1, 32'h44, 32'h99, acc);
        wait_req(0, "sp_rd");
        check_eq("sp_rd_cmd", 32'(m_cmd[0]), 32'd0);
        ack_pulse(0);
        m_rdata = 32'h5151_5151;
        tick();
        check_eq("sp_resp_valid", 32'(resp_valid[0]), 32'd1);
        check_eq("sp_resp_data",  resp_data[0],        32'h5151_5151);
        check_eq("sp_resp_level", 32'(level[0]),       32'd1);
        ack_pulse(0);
        check_eq("sp_after_req",   32'(m_req[0]),      32'd0);
        check_eq("sp_after_level", 32'(level[0]),      32'd1);
        check_eq("sp_after_resp",  32'(resp_valid[0]), 32'd0);
        tick();
        check_eq("sp_wr_req",  32'(m_req[0]), 32'd1);
        check_eq("sp_wr_cmd",  32'(m_cmd[0]), 32'd1);
        check_eq("sp_wr_addr", m_addr[0],     32'h44);
        ack_pulse(0);
        check_eq("sp_end_level", 32'(level[0]), 32'd0);

        // Reset while in RDWAIT with two entries queued
        reset_seq();
        push(2, 1'b0, 32'h60, 32'h0,  acc);
        push(2, 1'b1, 32'h64, 32'h11, acc);
        push(2, 1'b1, 32'h68, 32'h22, acc);
        wait_req(2, "rr");
        check_eq("rr_cmd", 32'(m_cmd[2]), 32'd0);
        ack_pulse(2);
        check_eq("rr_wait_level", 32'(level[2]), 32'd2);
        check_eq("rr_wait_req",   32'(m_req[2]), 32'd0);
        rst_b = 1'b0;
        tick();
        check_eq("rr_req",      32'(m_req[2]),      32'd0);
        check_eq("rr_level",    32'(level[2]),      32'd0);
        check_eq("rr_resp",     32'(resp_valid[2]), 32'd0);
        check_eq("rr_in_ready", 32'(in_ready[2]),   32'd0);
        rst_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid[2] || m_req[2]) seen = 1'b1;
        end
        check_eq("rr_quiet", 32'(seen), 32'd0);
        push(2, 1'b1, 32'h7C, 32'h77, acc);
        check_eq("rr_new_accept", 32'(acc), 32'd1);
        wait_req(2, "rr_new");
        check_eq("rr_new_addr",  m_addr[2],  32'h7C);
        check_eq("rr_new_wdata", m_wdata[2], 32'h77);
        ack_pulse(2);
        check_eq("rr_new_level", 32'(level[2]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
